// File: rtl/hd44780_responder.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module : hd44780_responder
// HD44780-style LCD bus responder: 32-char DDRAM buffer, busy flag, address
// counter. Define HD44780_RESP_READ_EN to support bus read cycles.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module hd44780_responder #(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       err,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char
);

  localparam int              CW          = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0]   c_CMD_LOAD  = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0]   c_HOME_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0]   c_CLR_LOAD  = CW'(CLEAR_CYCLES - 33);
  localparam logic [7:0]      c_SPACE     = 8'h20;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_IDLE     = 2'd1,
    S_BUSY     = 2'd2,
    S_CLEARING = 2'd3
  } state_t;

  logic       r_e_s1, r_e_s2, r_e_d;
  logic       r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0] r_d_s1, r_d_s2;
  logic       r_rs_cap, r_rw_cap;
  logic [7:0] r_d_cap;
  logic       r_strobe;

  state_t     r_state;
  logic [4:0] r_fill;
  logic [CW-1:0] r_cnt;
  logic [6:0] r_ac;
  logic       r_inc;
  logic       r_busy;
  logic [7:0] r_buf [0:31];

  logic [4:0] w_idx;
  logic [6:0] w_ac_next;
  logic       w_addr_ok;
  logic       w_fall;

  assign w_idx     = {r_ac[6], r_ac[3:0]};
  assign w_addr_ok = (r_d_cap[5:4] == 2'b00);
  assign w_fall    = r_e_d & ~r_e_s2;
  assign busy      = r_busy;
  assign addr      = r_ac;

  // AC walks the two 16-char lines as one 32-entry ring
  always_comb begin
    w_ac_next = r_ac;
    if (r_inc) begin
      if (r_ac == 7'h0F)      w_ac_next = 7'h40;
      else if (r_ac == 7'h4F) w_ac_next = 7'h00;
      else                    w_ac_next = r_ac + 7'd1;
    end else begin
      if (r_ac == 7'h00)      w_ac_next = 7'h4F;
      else if (r_ac == 7'h40) w_ac_next = 7'h0F;
      else                    w_ac_next = r_ac - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_s1   <= 1'b0;  r_e_s2  <= 1'b0;  r_e_d   <= 1'b0;
      r_rs_s1  <= 1'b0;  r_rs_s2 <= 1'b0;
      r_rw_s1  <= 1'b0;  r_rw_s2 <= 1'b0;
      r_d_s1   <= 8'h00; r_d_s2  <= 8'h00;
      r_rs_cap <= 1'b0;  r_rw_cap <= 1'b0; r_d_cap <= 8'h00;
      r_strobe <= 1'b0;
    end else begin
      r_e_s1  <= e;       r_e_s2  <= r_e_s1;  r_e_d <= r_e_s2;
      r_rs_s1 <= rs;      r_rs_s2 <= r_rs_s1;
      r_rw_s1 <= rw;      r_rw_s2 <= r_rw_s1;
      r_d_s1  <= data_in; r_d_s2  <= r_d_s1;
      if (r_e_s2) begin
        r_rs_cap <= r_rs_s2;
        r_rw_cap <= r_rw_s2;
        r_d_cap  <= r_d_s2;
      end
      r_strobe <= w_fall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_fill     <= 5'd0;
      r_cnt      <= '0;
      r_ac       <= 7'h00;
      r_inc      <= 1'b1;
      r_busy     <= 1'b1;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= 8'h00;
      err        <= 1'b0;
      rd_char    <= 8'h00;
      for (int i = 0; i < 32; i++) r_buf[i] <= c_SPACE;
    end else begin
      cmd_strobe <= 1'b0;
      rd_char    <= r_buf[rd_idx];
      case (r_state)
        S_INIT: begin
          r_buf[r_fill] <= c_SPACE;
          r_fill        <= r_fill + 5'd1;
          if (r_fill == 5'd31) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CLEARING: begin
          r_buf[r_fill] <= c_SPACE;
          r_fill        <= r_fill + 5'd1;
          if (r_fill == 5'd31) begin
            r_state <= S_BUSY;
            r_cnt   <= c_CLR_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_IDLE: begin
          if (r_strobe && !r_rw_cap) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= c_CMD_LOAD;
            if (r_rs_cap) begin
              r_buf[w_idx] <= r_d_cap;
              r_ac         <= w_ac_next;
            end else begin
              cmd_strobe <= 1'b1;
              cmd_byte   <= r_d_cap;
              // Highest set bit selects the instruction
              if (r_d_cap[7]) begin
                if (w_addr_ok) r_ac <= r_d_cap[6:0];
                else           err  <= 1'b1;
              end else if (|r_d_cap[6:4]) begin
              end else if (r_d_cap[3]) begin
                disp_on   <= r_d_cap[2];
                cursor_on <= r_d_cap[1];
                blink_on  <= r_d_cap[0];
              end else if (r_d_cap[2]) begin
                r_inc <= r_d_cap[1];
              end else if (r_d_cap[1]) begin
                r_ac  <= 7'h00;
                r_cnt <= c_HOME_LOAD;
              end else if (r_d_cap[0]) begin
                r_ac    <= 7'h00;
                r_inc   <= 1'b1;
                r_fill  <= 5'd0;
                r_state <= S_CLEARING;
              end
            end
          end
        end
        default: r_state <= S_INIT;
      endcase

      if (r_strobe) begin
        if (!r_rw_cap) begin
          if (r_state != S_IDLE) err <= 1'b1;
        end else begin
`ifdef HD44780_RESP_READ_EN
          if (r_rs_cap) begin
            if (r_state != S_IDLE) err  <= 1'b1;
            else                   r_ac <= w_ac_next;
          end
`else
          err <= 1'b1;
`endif
        end
      end
    end
  end

`ifdef HD44780_RESP_READ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_oe  <= 1'b0;
      data_out <= 8'h00;
    end else if (r_e_s2 && r_rw_s2) begin
      data_oe  <= 1'b1;
      data_out <= r_rs_s2 ? r_buf[w_idx] : {r_busy, r_ac};
    end else begin
      data_oe  <= 1'b0;
      data_out <= 8'h00;
    end
  end
`else
  assign data_oe  = 1'b0;
  assign data_out = 8'h00;
`endif

endmodule
`default_nettype wire
